// File: rtl/sgd_rd_pkg.sv
// rtl/sgd_rd_pkg.sv - shared tags, beat size and FSM states for the HBM read scheduler
package sgd_rd_pkg;

  localparam int MEM_RD_A_TAG = 1;
  localparam int MEM_RD_B_TAG = 2;
  localparam int BEAT_BYTES   = 32;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ISSUE,
    DRAIN,
    DONE
  } rd_state_e;

endpackage

// File: rtl/rd_stream_addr_gen.sv
// rtl/rd_stream_addr_gen.sv - per-stream address/remaining-beat counters and burst eligibility
module rd_stream_addr_gen
  import sgd_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 33,
  parameter int BURST_LEN  = 16,
  parameter int CW         = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [31:0]           length_i,
  input  logic                  advance_i,
  input  logic [CW-1:0]         credit_avail_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [4:0]            size_o,
  output logic                  pending_o,
  output logic                  eligible_o
);

  logic [26:0]           rem_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  unused_len_bits;

  // Lengths are whole beats, so the sub-beat bits carry no information.
  assign unused_len_bits = ^length_i[4:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      addr_q <= '0;
    end else if (load_i) begin
      rem_q  <= length_i[31:5];
      addr_q <= base_i;
    end else if (advance_i) begin
      rem_q  <= rem_q - 27'(size_o);
      addr_q <= addr_q + ADDR_WIDTH'(size_o) * ADDR_WIDTH'(BEAT_BYTES);
    end
  end

  assign size_o     = (rem_q < 27'(BURST_LEN)) ? rem_q[4:0] : 5'(BURST_LEN);
  assign addr_o     = addr_q;
  assign pending_o  = (rem_q != '0);
  assign eligible_o = pending_o && (CW'(size_o) <= credit_avail_i);

endmodule

// File: rtl/hbm_rd_scheduler.sv
// rtl/hbm_rd_scheduler.sv - round-robin, credit-throttled AR burst issue for streams A and B
module hbm_rd_scheduler
  import sgd_rd_pkg::*;
#(
  parameter int ADDR_WIDTH      = 33,
  parameter int ID_WIDTH        = 6,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] a_base_addr,
  input  logic [31:0]           a_length,
  input  logic [ADDR_WIDTH-1:0] b_base_addr,
  input  logic [31:0]           b_length,
  output logic                  m_axi_ARVALID,
  input  logic                  m_axi_ARREADY,
  output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
  output logic [3:0]            m_axi_ARLEN,
  output logic [ID_WIDTH-1:0]   m_axi_ARID,
  output logic [2:0]            m_axi_ARSIZE,
  output logic [1:0]            m_axi_ARBURST,
  input  logic                  m_axi_RVALID,
  input  logic                  m_axi_RREADY,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            outstanding_beats
);

  localparam int CW = 9;

  rd_state_e             state_q;
  logic                  arvalid_q, busy_q, done_q, rr_last_b_q, cur_b_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [3:0]            arlen_q;
  logic [ID_WIDTH-1:0]   arid_q;
  logic [7:0]            outstanding_q, outstanding_d;

  logic                  ar_hs, r_hs, load, grant_b;
  logic [CW-1:0]         credit_avail;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic [4:0]            size_a, size_b;
  logic                  pend_a, pend_b, elig_a, elig_b;

  assign ar_hs        = arvalid_q && m_axi_ARREADY;
  assign r_hs         = m_axi_RVALID && m_axi_RREADY;
  assign load         = (state_q == IDLE) && start;
  assign credit_avail = CW'(MAX_OUTSTANDING) - CW'(outstanding_q);

  rd_stream_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BURST_LEN(BURST_LEN), .CW(CW)) u_gen_a (
    .clk(clk), .rst_n(rst_n), .load_i(load), .base_i(a_base_addr), .length_i(a_length),
    .advance_i(ar_hs && !cur_b_q), .credit_avail_i(credit_avail),
    .addr_o(addr_a), .size_o(size_a), .pending_o(pend_a), .eligible_o(elig_a)
  );

  rd_stream_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BURST_LEN(BURST_LEN), .CW(CW)) u_gen_b (
    .clk(clk), .rst_n(rst_n), .load_i(load), .base_i(b_base_addr), .length_i(b_length),
    .advance_i(ar_hs && cur_b_q), .credit_avail_i(credit_avail),
    .addr_o(addr_b), .size_o(size_b), .pending_o(pend_b), .eligible_o(elig_b)
  );

  // On a tie the stream that did not win last time gets the grant.
  assign grant_b = elig_b && (!elig_a || !rr_last_b_q);

  always_comb begin
    outstanding_d = outstanding_q;
    if (ar_hs) outstanding_d = outstanding_d + 8'(arlen_q) + 8'd1;
    if (r_hs && outstanding_d != 8'd0) outstanding_d = outstanding_d - 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      arid_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rr_last_b_q   <= 1'b1;
      cur_b_q       <= 1'b0;
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q      <= 1'b1;
            rr_last_b_q <= 1'b1;
            state_q     <= ARB;
          end
        end
        ARB: begin
          if (elig_a || elig_b) begin
            cur_b_q     <= grant_b;
            rr_last_b_q <= grant_b;
            araddr_q    <= grant_b ? addr_b : addr_a;
            arlen_q     <= 4'((grant_b ? size_b : size_a) - 5'd1);
            arid_q      <= grant_b ? ID_WIDTH'(MEM_RD_B_TAG) : ID_WIDTH'(MEM_RD_A_TAG);
            arvalid_q   <= 1'b1;
            state_q     <= ISSUE;
          end else if (!pend_a && !pend_b) begin
            state_q <= DRAIN;
          end
        end
        ISSUE: begin
          if (m_axi_ARREADY) begin
            arvalid_q <= 1'b0;
            state_q   <= ARB;
          end
        end
        DRAIN: begin
          if (outstanding_q == 8'd0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) r_hs |-> (outstanding_q != 8'd0 || ar_hs));

  assign m_axi_ARVALID     = arvalid_q;
  assign m_axi_ARADDR      = araddr_q;
  assign m_axi_ARLEN       = arlen_q;
  assign m_axi_ARID        = arid_q;
  assign m_axi_ARSIZE      = 3'b101;
  assign m_axi_ARBURST     = 2'b01;
  assign busy              = busy_q;
  assign done              = done_q;
  assign outstanding_beats = outstanding_q;

endmodule

// File: tb/tb_hbm_rd_scheduler.sv
// tb/tb_hbm_rd_scheduler.sv - directed self-checking bench for hbm_rd_scheduler
module tb_hbm_rd_scheduler;
  import sgd_rd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, arready, rvalid, rready;
  logic [32:0] a_base, b_base;
  logic [31:0] a_len, b_len;
  logic        arvalid, busy, done;
  logic [32:0] araddr;
  logic [3:0]  arlen;
  logic [5:0]  arid;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [7:0]  outst;

  int checks = 0;
  int failures = 0;

  int          cyc = 0;
  int          ar_cnt = 0;
  logic [32:0] hs_addr [64];
  logic [3:0]  hs_len  [64];
  logic [5:0]  hs_id   [64];
  int          hs_cyc  [64];

  localparam logic [5:0] TAG_A = 6'(MEM_RD_A_TAG);
  localparam logic [5:0] TAG_B = 6'(MEM_RD_B_TAG);

  hbm_rd_scheduler #(.ADDR_WIDTH(33), .ID_WIDTH(6), .BURST_LEN(16), .MAX_OUTSTANDING(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_base_addr(a_base), .a_length(a_len), .b_base_addr(b_base), .b_length(b_len),
    .m_axi_ARVALID(arvalid), .m_axi_ARREADY(arready), .m_axi_ARADDR(araddr),
    .m_axi_ARLEN(arlen), .m_axi_ARID(arid), .m_axi_ARSIZE(arsize), .m_axi_ARBURST(arburst),
    .m_axi_RVALID(rvalid), .m_axi_RREADY(rready),
    .busy(busy), .done(done), .outstanding_beats(outst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && arvalid && arready) begin
      hs_addr[ar_cnt % 64] <= araddr;
      hs_len[ar_cnt % 64]  <= arlen;
      hs_id[ar_cnt % 64]   <= arid;
      hs_cyc[ar_cnt % 64]  <= cyc;
      ar_cnt <= ar_cnt + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [32:0] ab, input logic [31:0] al,
                          input logic [32:0] bb, input logic [31:0] bl);
    @(posedge clk); #1;
    a_base = ab; a_len = al; b_base = bb; b_len = bl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_ar(input int target, output bit ok);
    for (int k = 0; k < 200 && ar_cnt < target; k++) tick();
    ok = (ar_cnt >= target);
  endtask

  task automatic wait_arvalid(output bit ok);
    for (int k = 0; k < 20 && !arvalid; k++) tick();
    ok = arvalid;
  endtask

  task automatic finish_run(output bit got);
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      rvalid = (outst != 8'd0);
      tick();
      if (done) got = 1'b1;
    end
    rvalid = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL rst_arvalid: got %b exp 0", arvalid); end
    checks++; if (araddr !== 33'd0) begin failures++; $display("FAIL rst_araddr: got %h exp 0", araddr); end
    checks++; if (arlen !== 4'd0) begin failures++; $display("FAIL rst_arlen: got %0d exp 0", arlen); end
    checks++; if (arid !== 6'd0) begin failures++; $display("FAIL rst_arid: got %0d exp 0", arid); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done: got %b%b exp 00", busy, done); end
    checks++; if (outst !== 8'd0) begin failures++; $display("FAIL rst_outst: got %0d exp 0", outst); end
    checks++; if (arsize !== 3'b101 || arburst !== 2'b01) begin failures++; $display("FAIL rst_size_burst: got %b %b exp 101 01", arsize, arburst); end
  endtask

  task automatic test_single_stream;
    int b0;
    bit ok;
    b0 = ar_cnt;
    arready = 1'b1;
    do_start(33'h0_4000_1000, 32'd1024, 33'h0_8000_0000, 32'd0);
    checks++; if (arvalid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL ss_cycle1: got arvalid=%b busy=%b exp 0 1", arvalid, busy); end
    tick();
    checks++; if (arvalid !== 1'b1 || araddr !== 33'h0_4000_1000 || arlen !== 4'd15 || arid !== TAG_A) begin
      failures++; $display("FAIL ss_cycle2: got v=%b addr=%h len=%0d id=%0d exp 1 040001000 15 %0d", arvalid, araddr, arlen, arid, TAG_A); end
    wait_ar(b0 + 2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ss_ar_count: got %0d exp %0d", ar_cnt - b0, 2); end
    checks++; if (hs_addr[b0+1] !== 33'h0_4000_1200 || hs_len[b0+1] !== 4'd15 || hs_id[b0+1] !== TAG_A) begin
      failures++; $display("FAIL ss_second_ar: got addr=%h len=%0d id=%0d exp 040001200 15 %0d", hs_addr[b0+1], hs_len[b0+1], hs_id[b0+1], TAG_A); end
    checks++; if (hs_cyc[b0+1] - hs_cyc[b0] !== 2) begin failures++; $display("FAIL ss_b2b_spacing: got %0d exp 2", hs_cyc[b0+1] - hs_cyc[b0]); end
    checks++; if (outst !== 8'd32) begin failures++; $display("FAIL ss_outst_full: got %0d exp 32", outst); end
    repeat (3) tick();
    rvalid = 1'b1;
    repeat (32) @(posedge clk);
    #1 rvalid = 1'b0;
    checks++; if (outst !== 8'd0 || done !== 1'b0) begin failures++; $display("FAIL ss_t1: got outst=%0d done=%b exp 0 0", outst, done); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL ss_done_t2: got %b exp 1", done); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ss_after_done: got done=%b busy=%b exp 0 0", done, busy); end
    checks++; if (ar_cnt - b0 !== 2) begin failures++; $display("FAIL ss_total_ar: got %0d exp 2", ar_cnt - b0); end
  endtask

  task automatic test_alternate;
    int b0;
    bit ok, got;
    b0 = ar_cnt;
    do_start(33'h1_0000_0000, 32'd512, 33'h0_0020_0000, 32'd512);
    wait_ar(b0 + 2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL alt_ar_count: got %0d exp 2", ar_cnt - b0); end
    checks++; if (hs_addr[b0] !== 33'h1_0000_0000 || hs_id[b0] !== TAG_A || hs_len[b0] !== 4'd15) begin
      failures++; $display("FAIL alt_first_a: got addr=%h id=%0d len=%0d exp 100000000 %0d 15", hs_addr[b0], hs_id[b0], hs_len[b0], TAG_A); end
    checks++; if (hs_addr[b0+1] !== 33'h0_0020_0000 || hs_id[b0+1] !== TAG_B || hs_len[b0+1] !== 4'd15) begin
      failures++; $display("FAIL alt_second_b: got addr=%h id=%0d len=%0d exp 000200000 %0d 15", hs_addr[b0+1], hs_id[b0+1], hs_len[b0+1], TAG_B); end
    finish_run(got);
    checks++; if (!got) begin failures++; $display("FAIL alt_done: got no done exp done"); end
    checks++; if (ar_cnt - b0 !== 2) begin failures++; $display("FAIL alt_total_ar: got %0d exp 2", ar_cnt - b0); end
  endtask

  task automatic test_short_burst;
    int b0;
    bit ok, got;
    b0 = ar_cnt;
    do_start(33'h0_0000_0400, 32'd96, 33'h0_0000_0000, 32'd0);
    wait_ar(b0 + 1, ok);
    checks++; if (!ok || hs_len[b0] !== 4'd2 || hs_addr[b0] !== 33'h0_0000_0400) begin
      failures++; $display("FAIL sb_burst: got ok=%b len=%0d addr=%h exp 1 2 000000400", ok, hs_len[b0], hs_addr[b0]); end
    repeat (5) tick();
    checks++; if (arvalid !== 1'b0 || outst !== 8'd3 || busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL sb_drain: got v=%b outst=%0d busy=%b done=%b exp 0 3 1 0", arvalid, outst, busy, done); end
    finish_run(got);
    checks++; if (!got || ar_cnt - b0 !== 1) begin failures++; $display("FAIL sb_done: got done=%b ars=%0d exp 1 1", got, ar_cnt - b0); end
  endtask

  task automatic test_credit_stall;
    int b0;
    bit ok, got;
    b0 = ar_cnt;
    do_start(33'h0_1000_0000, 32'd2048, 33'h0_0000_0000, 32'd0);
    wait_ar(b0 + 2, ok);
    repeat (20) tick();
    checks++; if (ar_cnt - b0 !== 2 || arvalid !== 1'b0 || outst !== 8'd32) begin
      failures++; $display("FAIL cs_stall: got ars=%0d v=%b outst=%0d exp 2 0 32", ar_cnt - b0, arvalid, outst); end
    rvalid = 1'b1;
    repeat (15) @(posedge clk);
    #1 rvalid = 1'b0;
    repeat (4) tick();
    checks++; if (ar_cnt - b0 !== 2 || outst !== 8'd17) begin
      failures++; $display("FAIL cs_15_free: got ars=%0d outst=%0d exp 2 17", ar_cnt - b0, outst); end
    rvalid = 1'b1;
    @(posedge clk);
    #1 rvalid = 1'b0;
    wait_ar(b0 + 3, ok);
    checks++; if (!ok || hs_addr[b0+2] !== 33'h0_1000_0400) begin
      failures++; $display("FAIL cs_third_ar: got ok=%b addr=%h exp 1 010000400", ok, hs_addr[b0+2]); end
    finish_run(got);
    checks++; if (!got || ar_cnt - b0 !== 4 || hs_addr[b0+3] !== 33'h0_1000_0600) begin
      failures++; $display("FAIL cs_finish: got done=%b ars=%0d addr=%h exp 1 4 010000600", got, ar_cnt - b0, hs_addr[b0+3]); end
  endtask

  task automatic test_arready_hold;
    int b0;
    bit ok, got;
    b0 = ar_cnt;
    arready = 1'b0;
    do_start(33'h1_2345_6000, 32'd512, 33'h0_0000_0000, 32'd0);
    wait_arvalid(ok);
    checks++; if (!ok) begin failures++; $display("FAIL hold_arvalid: got 0 exp 1"); end
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin a_base = 33'h0_0BAD_0000; a_len = 32'd64; start = 1'b1; end
      if (i == 5) start = 1'b0;
      checks++; if (arvalid !== 1'b1 || araddr !== 33'h1_2345_6000 || arlen !== 4'd15 || arid !== TAG_A || ar_cnt !== b0) begin
        failures++; $display("FAIL hold_stable[%0d]: got v=%b addr=%h len=%0d id=%0d ars=%0d exp 1 123456000 15 %0d 0", i, arvalid, araddr, arlen, arid, ar_cnt - b0, TAG_A); end
      tick();
    end
    arready = 1'b1;
    wait_ar(b0 + 1, ok);
    repeat (5) tick();
    checks++; if (ar_cnt - b0 !== 1 || hs_addr[b0] !== 33'h1_2345_6000) begin
      failures++; $display("FAIL hold_one_hs: got ars=%0d addr=%h exp 1 123456000", ar_cnt - b0, hs_addr[b0]); end
    finish_run(got);
    checks++; if (!got) begin failures++; $display("FAIL hold_done: got no done exp done"); end
  endtask

  task automatic test_zero_length;
    int b0;
    b0 = ar_cnt;
    do_start(33'h0_0000_0000, 32'd0, 33'h0_0000_0000, 32'd0);
    checks++; if (done !== 1'b0 || arvalid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL zl_c1: got done=%b v=%b busy=%b exp 0 0 1", done, arvalid, busy); end
    tick();
    checks++; if (done !== 1'b0 || arvalid !== 1'b0) begin failures++; $display("FAIL zl_c2: got done=%b v=%b exp 0 0", done, arvalid); end
    tick();
    checks++; if (done !== 1'b1 || arvalid !== 1'b0) begin failures++; $display("FAIL zl_c3: got done=%b v=%b exp 1 0", done, arvalid); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || ar_cnt !== b0) begin failures++; $display("FAIL zl_c4: got done=%b busy=%b ars=%0d exp 0 0 0", done, busy, ar_cnt - b0); end
  endtask

  task automatic test_reset_mid_issue;
    bit ok;
    arready = 1'b0;
    do_start(33'h0_2000_0000, 32'd512, 33'h0_3000_0000, 32'd512);
    wait_arvalid(ok);
    checks++; if (!ok || busy !== 1'b1) begin failures++; $display("FAIL rmi_issue: got v=%b busy=%b exp 1 1", ok, busy); end
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b0 || busy !== 1'b0 || outst !== 8'd0 || araddr !== 33'd0) begin
      failures++; $display("FAIL rmi_cleared: got v=%b busy=%b outst=%0d addr=%h exp 0 0 0 0", arvalid, busy, outst, araddr); end
    tick();
    rst_n = 1'b1;
    arready = 1'b1;
    repeat (3) tick();
    checks++; if (arvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmi_idle: got v=%b busy=%b exp 0 0", arvalid, busy); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; arready = 1'b1; rvalid = 1'b0; rready = 1'b1;
    a_base = '0; b_base = '0; a_len = '0; b_len = '0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single_stream();
    test_alternate();
    test_short_burst();
    test_credit_stall();
    test_arready_hold();
    test_zero_length();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hbm_rd_scheduler.md
# hbm_rd_scheduler

Issues AXI3 read-address bursts to one HBM pseudo-channel on behalf of two streams, the sample matrix A (tag MEM_RD_A_TAG) and the label/model vector B (tag MEM_RD_B_TAG). It sits in front of the read-response dispatcher. It shares the single AR channel between the two streams with round-robin arbitration and throttles issue against a beat-credit budget that matches the downstream A/B buffering. It reports completion once every requested beat has returned.

## Interface
- ADDR_WIDTH, 33: HBM byte-address width.
- ID_WIDTH, 6: ARID width.
- BURST_LEN, 16: maximum beats per burst, 32 B each; valid range 1..16.
- MAX_OUTSTANDING, 64: maximum requested-but-not-returned beats; must be at least BURST_LEN.

- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; sampled only in IDLE.
- a_base_addr  in  ADDR_WIDTH  A start address; 512 B aligned.
- a_length  in  32  A length in bytes; multiple of 32.
- b_base_addr  in  ADDR_WIDTH  B start address; 512 B aligned.
- b_length  in  32  B length in bytes; multiple of 32.
- m_axi_ARVALID  out  1  address valid.
- m_axi_ARREADY  in  1  address accepted.
- m_axi_ARADDR  out  ADDR_WIDTH  burst start address.
- m_axi_ARLEN  out  4  beats minus 1.
- m_axi_ARID  out  ID_WIDTH  MEM_RD_A_TAG or MEM_RD_B_TAG.
- m_axi_ARSIZE  out  3  constant 3'b101.
- m_axi_ARBURST  out  2  constant 2'b01 (INCR).
- m_axi_RVALID  in  1  monitored only.
- m_axi_RREADY  in  1  monitored only; driven by the dispatcher.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when all beats have returned.
- outstanding_beats  out  8  current credit usage, for debug.

## Operation
- Per stream:
  - rem_beats = length>>5, latched at start.
  - Address counter initialised to base.
  - Burst size = min(rem_beats, BURST_LEN).
  - On AR handshake: address += size*32; rem_beats -= size.
- A stream is eligible when rem_beats != 0 and outstanding_beats + size <= MAX_OUTSTANDING.
- Arbitration:
  - Round-robin between eligible streams; the last-granted stream loses ties.
  - After start, A has the first tie-break.
- States:
  - IDLE: wait for start. On start, latch the inputs and go to ARB.
  - ARB: pick a stream and load the AR registers, then go to ISSUE. If no stream is eligible but rem_beats != 0, stay in ARB. If both rem_beats == 0, go to DRAIN.
  - ISSUE: hold ARVALID and all AR fields stable until ARREADY. On the handshake, update that stream's counters and credit, then go to ARB.
  - DRAIN: go to DONE when outstanding_beats == 0.
  - DONE: assert done for one cycle, then go to IDLE.
- Credit accounting:
  - outstanding_beats += (ARLEN+1) on AR handshake.
  - outstanding_beats -= 1 on each RVALID&RREADY.
  - Both in the same cycle: apply the net change.
  - A decrement at 0 is impossible by construction; assert it in simulation.
- Boundary cases:
  - start while busy: ignored.
  - a_length = b_length = 0: IDLE→ARB→DRAIN→DONE, with done 3 cycles after start and no AR issued.
  - Reset mid-burst: all state clears immediately and ARVALID drops. Beats still in flight are the system's concern; the scheduler does not count them.

## Timing
- Reset values:
  - m_axi_ARVALID = 0, ARADDR = 0, ARLEN = 0, ARID = 0.
  - busy = 0, done = 0, outstanding_beats = 0.
  - FSM in IDLE; round-robin pointer favours A.
- Latency:
  - start at cycle 0 → ARB at cycle 1 → ARVALID first high at cycle 2.
  - Back-to-back issue takes 2 cycles per burst (ISSUE→ARB→ISSUE) when ARREADY is constantly high.
  - Last R beat at cycle t → outstanding_beats = 0 at t+1 → done at t+2.
- All AR outputs are registered. Credit is checked in ARB using the registered outstanding_beats.

## Structure
- Shared package sgd_rd_pkg holds:
  - MEM_RD_A_TAG and MEM_RD_B_TAG, consistent with sgd_defines.vh.
  - BEAT_BYTES = 32.
  - The state enum {IDLE, ARB, ISSUE, DRAIN, DONE}.
- Sub-module rd_stream_addr_gen covers the per-stream base/remaining counters, burst-size computation and the eligibility input. It is instantiated twice, for A and B.
- The top level contains the arbiter, FSM, credit counter and AR registers.

## Test plan
- a_length=1024, b_length=0, ARREADY=1 → two bursts at a_base and a_base+512, both ARLEN=15, ARID=A tag. done pulses 2 cycles after the 32nd R beat.
- a_length=b_length=512, ARREADY=1 → ARs alternate A then B. Each has ARLEN=15 and carries the correct tag.
- a_length=96 → single burst with ARLEN=2. rem_beats reaches 0 and the FSM goes to DRAIN.
- MAX_OUTSTANDING=32, a_length=2048, RVALID held 0 → exactly 2 ARs issued, then the FSM stalls in ARB. Releasing 16 beats allows the 3rd AR.
- ARREADY low for 10 cycles during ISSUE → ARVALID, ARADDR, ARLEN and ARID stay stable. There is exactly one handshake.
- Lengths both 0 → done at cycle 3 with no ARVALID. Separately, rst_n low mid-ISSUE → ARVALID drops immediately and busy=0.
